// File: rtl/dual_issue_pkg.sv
// Shared types and helpers for the dual-issue controller.
//   issue_state_e : PAIR (both slots issue) / SPLIT (slot 2 issues alone after slot 1)
//   REG_AW        : register-index width
//   CNT_W         : performance counter width (ISSUE_PERF_EN builds only)
//   src_match     : destination rd hits rs1 or rs2, with x0 never matching
package dual_issue_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [0:0] {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } issue_state_e;

  function automatic logic src_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode/execute-to-issue-controller bundle.
//   master : pipeline side; drives decode/execute status, receives stall/bubble/redirect controls
//   slave  : issue controller
// With ISSUE_PERF_EN defined the bundle also carries PairCnt, SplitCnt and LuCnt.
interface dual_issue_ctrl_if;
  import dual_issue_pkg::*;

  logic              ValidD1, ValidD2;
  logic [REG_AW-1:0] RdD1;
  logic              RegWriteD1;
  logic [REG_AW-1:0] Rs1D1, Rs2D1, Rs1D2, Rs2D2;
  logic              MemD1, MemD2;
  logic              CtrlD1;
  logic              MemReadE1, MemReadE2;
  logic [REG_AW-1:0] RdE1, RdE2;
  logic              TakenE1, TakenE2;

  logic              StallF, StallD1, StallD2;
  logic              BubbleE1, BubbleE2;
  logic              FlushD;
  logic              BranchIn1, BranchIn2;
  logic              SplitS;
`ifdef ISSUE_PERF_EN
  logic [CNT_W-1:0]  PairCnt, SplitCnt, LuCnt;
`endif

  modport master (
    output ValidD1, ValidD2, RdD1, RegWriteD1, Rs1D1, Rs2D1, Rs1D2, Rs2D2,
    output MemD1, MemD2, CtrlD1, MemReadE1, MemReadE2, RdE1, RdE2, TakenE1, TakenE2,
    input  StallF, StallD1, StallD2, BubbleE1, BubbleE2, FlushD, BranchIn1, BranchIn2,
`ifdef ISSUE_PERF_EN
    input  PairCnt, SplitCnt, LuCnt,
`endif
    input  SplitS
  );

  modport slave (
    input  ValidD1, ValidD2, RdD1, RegWriteD1, Rs1D1, Rs2D1, Rs1D2, Rs2D2,
    input  MemD1, MemD2, CtrlD1, MemReadE1, MemReadE2, RdE1, RdE2, TakenE1, TakenE2,
    output StallF, StallD1, StallD2, BubbleE1, BubbleE2, FlushD, BranchIn1, BranchIn2,
`ifdef ISSUE_PERF_EN
    output PairCnt, SplitCnt, LuCnt,
`endif
    output SplitS
  );

endinterface

// File: rtl/issue_hazard_detect.sv
// Combinational hazard terms for the decoded pair.
//   conflict_o : pair must serialise (slot1->slot2 RAW, two memory ops, or slot-1 control flow)
//   lu_o       : an execute-stage load feeds a source that has not issued yet
//   split_i    : slot 1 already issued, so only slot-2 sources are still live
module issue_hazard_detect
  import dual_issue_pkg::*;
(
  input  logic              valid_d1_i,
  input  logic              valid_d2_i,
  input  logic [REG_AW-1:0] rd_d1_i,
  input  logic              reg_write_d1_i,
  input  logic [REG_AW-1:0] rs1_d1_i,
  input  logic [REG_AW-1:0] rs2_d1_i,
  input  logic [REG_AW-1:0] rs1_d2_i,
  input  logic [REG_AW-1:0] rs2_d2_i,
  input  logic              mem_d1_i,
  input  logic              mem_d2_i,
  input  logic              ctrl_d1_i,
  input  logic              mem_read_e1_i,
  input  logic              mem_read_e2_i,
  input  logic [REG_AW-1:0] rd_e1_i,
  input  logic [REG_AW-1:0] rd_e2_i,
  input  logic              split_i,
  output logic              conflict_o,
  output logic              lu_o
);

  logic raw, mem, live1, live2, hit_e1, hit_e2;

  always_comb begin
    raw        = reg_write_d1_i && src_match(rd_d1_i, rs1_d2_i, rs2_d2_i);
    mem        = mem_d1_i && mem_d2_i;
    conflict_o = valid_d1_i && valid_d2_i && (raw || mem || ctrl_d1_i);

    live1  = valid_d1_i && !split_i;
    live2  = valid_d2_i;
    hit_e1 = (live1 && src_match(rd_e1_i, rs1_d1_i, rs2_d1_i)) ||
             (live2 && src_match(rd_e1_i, rs1_d2_i, rs2_d2_i));
    hit_e2 = (live1 && src_match(rd_e2_i, rs1_d1_i, rs2_d1_i)) ||
             (live2 && src_match(rd_e2_i, rs1_d2_i, rs2_d2_i));
    lu_o   = (mem_read_e1_i && hit_e1) || (mem_read_e2_i && hit_e2);
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue/hazard controller for the two-slot dual-issue core.
//   clk, rst : clock and synchronous active-high reset
//   bus      : dual_issue_ctrl_if.slave (decode/execute status in, fetch/decode/execute controls out)
// Priority: redirect > load-use > split > pair. Outputs are combinational from state + inputs and
// forced to zero while rst is high.
// Optional: define ISSUE_PERF_EN for PairCnt/SplitCnt/LuCnt performance counters.
module dual_issue_ctrl
  import dual_issue_pkg::*;
(
  input logic              clk,
  input logic              rst,
  dual_issue_ctrl_if.slave bus
);

  issue_state_e state_q, state_d;
  logic         conflict, lu;

  issue_hazard_detect u_hazard (
    .valid_d1_i    (bus.ValidD1),
    .valid_d2_i    (bus.ValidD2),
    .rd_d1_i       (bus.RdD1),
    .reg_write_d1_i(bus.RegWriteD1),
    .rs1_d1_i      (bus.Rs1D1),
    .rs2_d1_i      (bus.Rs2D1),
    .rs1_d2_i      (bus.Rs1D2),
    .rs2_d2_i      (bus.Rs2D2),
    .mem_d1_i      (bus.MemD1),
    .mem_d2_i      (bus.MemD2),
    .ctrl_d1_i     (bus.CtrlD1),
    .mem_read_e1_i (bus.MemReadE1),
    .mem_read_e2_i (bus.MemReadE2),
    .rd_e1_i       (bus.RdE1),
    .rd_e2_i       (bus.RdE2),
    .split_i       (state_q == SPLIT),
    .conflict_o    (conflict),
    .lu_o          (lu)
  );

  always_comb begin
    state_d       = state_q;
    bus.StallF    = 1'b0;
    bus.StallD1   = 1'b0;
    bus.StallD2   = 1'b0;
    bus.BubbleE1  = 1'b0;
    bus.BubbleE2  = 1'b0;
    bus.FlushD    = 1'b0;
    bus.BranchIn1 = 1'b0;
    bus.BranchIn2 = 1'b0;
    bus.SplitS    = 1'b0;
    if (!rst) begin
      bus.SplitS = (state_q == SPLIT);
      if (bus.TakenE1) begin
        // Older redirect wins and squashes the younger execute slot.
        bus.BranchIn1 = 1'b1;
        bus.BubbleE2  = 1'b1;
        bus.FlushD    = 1'b1;
        state_d       = PAIR;
      end else if (bus.TakenE2) begin
        bus.BranchIn2 = 1'b1;
        bus.FlushD    = 1'b1;
        state_d       = PAIR;
      end else if (lu) begin
        bus.StallF   = 1'b1;
        bus.StallD1  = 1'b1;
        bus.StallD2  = 1'b1;
        bus.BubbleE1 = 1'b1;
        bus.BubbleE2 = 1'b1;
      end else if (state_q == SPLIT) begin
        // Slot 1 went last cycle; only slot 2 issues now.
        bus.BubbleE1 = 1'b1;
        state_d      = PAIR;
      end else if (conflict) begin
        bus.BubbleE2 = 1'b1;
        bus.StallF   = 1'b1;
        bus.StallD1  = 1'b1;
        bus.StallD2  = 1'b1;
        state_d      = SPLIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= PAIR;
    else     state_q <= state_d;
  end

`ifdef ISSUE_PERF_EN
  logic             pair_evt, split_evt, lu_evt;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d, split_cnt_q, split_cnt_d, lu_cnt_q, lu_cnt_d;

  always_comb begin
    pair_evt    = !rst && (state_q == PAIR) && !bus.TakenE1 && !bus.TakenE2 && !lu &&
                  !conflict && bus.ValidD1 && bus.ValidD2;
    split_evt   = !rst && (state_q == PAIR) && (state_d == SPLIT);
    lu_evt      = !rst && !bus.TakenE1 && !bus.TakenE2 && lu;
    pair_cnt_d  = pair_cnt_q + CNT_W'(pair_evt);
    split_cnt_d = split_cnt_q + CNT_W'(split_evt);
    lu_cnt_d    = lu_cnt_q + CNT_W'(lu_evt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      pair_cnt_q  <= pair_cnt_d;
      split_cnt_q <= split_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign bus.PairCnt  = pair_cnt_q;
  assign bus.SplitCnt = split_cnt_q;
  assign bus.LuCnt    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
module tb_dual_issue_ctrl;
  import dual_issue_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       v1, v2;
    logic [4:0] rd1;
    logic       rw1;
    logic [4:0] rs11, rs21, rs12, rs22;
    logic       m1, m2, c1;
    logic       mr1, mr2;
    logic [4:0] rde1, rde2;
    logic       t1, t2;
  } stim_t;

  // ctl = {StallF, StallD1, StallD2, BubbleE1, BubbleE2, FlushD, BranchIn1, BranchIn2, SplitS}
  typedef struct {
    logic [8:0]  ctl;
    logic        cnt_ok;
    logic [31:0] pc, sc, lc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_issue_ctrl_if bus ();
  dual_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: "slot 1 already gone, slot 2 still waiting" plus event tallies.
  bit          slot2_waiting = 1'b0;
  logic [31:0] m_pair = '0, m_split = '0, m_lu = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want,
                       input int c);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, want);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s      = '0;
    s.v1   = ($urandom_range(0, 9) < 8);
    s.v2   = ($urandom_range(0, 9) < 8);
    s.rd1  = 5'($urandom_range(0, 3));
    s.rw1  = ($urandom_range(0, 9) < 7);
    s.rs11 = 5'($urandom_range(0, 3));
    s.rs21 = 5'($urandom_range(0, 3));
    s.rs12 = 5'($urandom_range(0, 3));
    s.rs22 = 5'($urandom_range(0, 3));
    s.m1   = ($urandom_range(0, 9) < 3);
    s.m2   = ($urandom_range(0, 9) < 3);
    s.c1   = ($urandom_range(0, 19) < 3);
    s.mr1  = ($urandom_range(0, 3) == 0);
    s.mr2  = ($urandom_range(0, 3) == 0);
    s.rde1 = 5'($urandom_range(0, 3));
    s.rde2 = 5'($urandom_range(0, 3));
    s.t1   = ($urandom_range(0, 9) == 0);
    s.t2   = ($urandom_range(0, 9) == 0);
    s.rst  = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  // Decide what the controller must do this cycle, straight from the issue rules.
  task automatic model(input stim_t s, output exp_t e);
    logic [4:0] src[4];
    bit         live[4];
    logic [4:0] eld[2];
    bit         eload[2];
    bit         loaduse, serialise;
    bit         stf, sd1, sd2, be1, be2, fl, br1, br2;
    e.cyc    = cyc;
    e.cnt_ok = !s.rst;
    e.pc     = m_pair;
    e.sc     = m_split;
    e.lc     = m_lu;
    {stf, sd1, sd2, be1, be2, fl, br1, br2} = '0;
    if (s.rst) begin
      e.ctl         = '0;
      slot2_waiting = 1'b0;
      m_pair        = '0;
      m_split       = '0;
      m_lu          = '0;
      return;
    end
    src   = '{s.rs11, s.rs21, s.rs12, s.rs22};
    live  = '{s.v1 && !slot2_waiting, s.v1 && !slot2_waiting, s.v2, s.v2};
    eld   = '{s.rde1, s.rde2};
    eload = '{s.mr1, s.mr2};
    loaduse = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        if (eload[k] && eld[k] != 0 && live[i] && src[i] == eld[k]) loaduse = 1'b1;
    serialise = s.v1 && s.v2 &&
                ((s.rw1 && s.rd1 != 0 && (s.rd1 == s.rs12 || s.rd1 == s.rs22)) ||
                 (s.m1 && s.m2) || s.c1);
    e.ctl[0] = slot2_waiting;
    if (s.t1) begin
      br1 = 1; be2 = 1; fl = 1;
      slot2_waiting = 1'b0;
    end else if (s.t2) begin
      br2 = 1; fl = 1;
      slot2_waiting = 1'b0;
    end else if (loaduse) begin
      stf = 1; sd1 = 1; sd2 = 1; be1 = 1; be2 = 1;
      m_lu++;
    end else if (slot2_waiting) begin
      be1 = 1;
      slot2_waiting = 1'b0;
    end else if (serialise) begin
      be2 = 1; stf = 1; sd1 = 1; sd2 = 1;
      slot2_waiting = 1'b1;
      m_split++;
    end else if (s.v1 && s.v2) begin
      m_pair++;
    end
    e.ctl[8:1] = {stf, sd1, sd2, be1, be2, fl, br1, br2};
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst            = s.rst;
    bus.ValidD1    = s.v1;
    bus.ValidD2    = s.v2;
    bus.RdD1       = s.rd1;
    bus.RegWriteD1 = s.rw1;
    bus.Rs1D1      = s.rs11;
    bus.Rs2D1      = s.rs21;
    bus.Rs1D2      = s.rs12;
    bus.Rs2D2      = s.rs22;
    bus.MemD1      = s.m1;
    bus.MemD2      = s.m2;
    bus.CtrlD1     = s.c1;
    bus.MemReadE1  = s.mr1;
    bus.MemReadE2  = s.mr2;
    bus.RdE1       = s.rde1;
    bus.RdE2       = s.rde2;
    bus.TakenE1    = s.t1;
    bus.TakenE2    = s.t2;
    model(s, e);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctl", 32'({bus.StallF, bus.StallD1, bus.StallD2, bus.BubbleE1, bus.BubbleE2,
                        bus.FlushD, bus.BranchIn1, bus.BranchIn2, bus.SplitS}),
            32'(e.ctl), e.cyc);
`ifdef ISSUE_PERF_EN
      if (e.cnt_ok) begin
        check("PairCnt", bus.PairCnt, e.pc, e.cyc);
        check("SplitCnt", bus.SplitCnt, e.sc, e.cyc);
        check("LuCnt", bus.LuCnt, e.lc, e.cyc);
      end
`endif
    end
  end

  initial begin
    stim_t s, raw, rst_s;
    bus.ValidD1 = 0; bus.ValidD2 = 0; bus.RdD1 = 0; bus.RegWriteD1 = 0;
    bus.Rs1D1 = 0; bus.Rs2D1 = 0; bus.Rs1D2 = 0; bus.Rs2D2 = 0;
    bus.MemD1 = 0; bus.MemD2 = 0; bus.CtrlD1 = 0; bus.MemReadE1 = 0; bus.MemReadE2 = 0;
    bus.RdE1 = 0; bus.RdE2 = 0; bus.TakenE1 = 0; bus.TakenE2 = 0;

    rst_s = idle(); rst_s.rst = 1;
    raw = idle(); raw.v1 = 1; raw.v2 = 1; raw.rd1 = 5; raw.rw1 = 1; raw.rs22 = 5;

    apply(rst_s); apply(rst_s); apply(idle());

    // Independent pair.
    s = idle(); s.v1 = 1; s.v2 = 1; s.rd1 = 5; s.rw1 = 1; s.rs12 = 6; s.rs22 = 7;
    apply(s);
    // RAW pair: split, then slot 2 alone, then back to pairing.
    apply(raw); apply(raw); apply(idle());
    // x0 destination never creates a RAW.
    s = idle(); s.v1 = 1; s.v2 = 1; s.rw1 = 1; s.rd1 = 0; s.rs12 = 0;
    apply(s);
    // Two memory ops.
    s = idle(); s.v1 = 1; s.v2 = 1; s.m1 = 1; s.m2 = 1;
    apply(s); apply(s); apply(idle());
    // Load-use in PAIR.
    s = idle(); s.v2 = 1; s.mr1 = 1; s.rde1 = 9; s.rs12 = 9;
    apply(s); apply(idle());
    // Load-use against a slot-1 source while in SPLIT: slot 1 is gone, no stall.
    apply(raw);
    s = raw; s.mr1 = 1; s.rde1 = 9; s.rs11 = 9;
    apply(s); apply(idle());
    // Both redirects during SPLIT.
    apply(raw);
    s = raw; s.t1 = 1; s.t2 = 1;
    apply(s); apply(idle());
    // Younger redirect alone.
    s = idle(); s.v1 = 1; s.t2 = 1;
    apply(s);
    // Reset during SPLIT.
    apply(raw);
    s = raw; s.rst = 1;
    apply(s); apply(idle());
    // Counter scenario: 3 pairs, 1 split, 2 load-use cycles.
    s = idle(); s.v1 = 1; s.v2 = 1; s.rs12 = 3;
    apply(s); apply(s); apply(s);
    apply(raw); apply(raw);
    s = idle(); s.v1 = 1; s.mr2 = 1; s.rde2 = 4; s.rs21 = 4;
    apply(s); apply(s); apply(idle()); apply(idle());

    for (int i = 0; i < 3000; i++) apply(rand_stim());
    apply(idle());

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0, cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
